// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM (fetch/decode/lw/sw/R/beq/addi/j) with memory wait timeout
//   in : clk, rst (async, active high), opcode[5:0], funct[5:0], zero, mem_ready
//   out: pc_en, pc_src[1:0], iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg,
//        alu_src_a, alu_src_b[1:0], alu_op[1:0], state[3:0], instr_done, err
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       err
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11,
    ERR = 4'd15
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t cur, nxt;
  logic [7:0] wcnt;
  logic wait_st, tmo;
  // funct only feeds the external ALU decoder
  logic unused_funct;
  assign unused_funct = ^funct;
  assign state = cur;
  assign wait_st = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  // a ready cycle always wins over a timeout in the same cycle
  assign tmo = wait_st && !mem_ready && (wcnt == 8'(MEM_TIMEOUT));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= FETCH;
      wcnt <= '0;
    end else begin
      cur  <= nxt;
      wcnt <= (nxt != cur) ? '0 : (wait_st && !mem_ready) ? wcnt + 8'd1 : wcnt;
    end
  end
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : tmo ? ERR : FETCH;
      DECODE: nxt = (opcode == OP_R) ? EXEC :
                    (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    (opcode == OP_BEQ) ? BRANCH :
                    (opcode == OP_ADDI) ? ADDIEX :
                    (opcode == OP_J) ? JUMP : ERR;
      MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : tmo ? ERR : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : tmo ? ERR : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      default: nxt = ERR;
    endcase
  end
  // outputs are held low while rst is asserted so no strobe leaks during reset
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    instr_done = 1'b0;
    err        = 1'b0;
    if (!rst) begin
      case (cur)
        FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          ir_wr     = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE: alu_src_b = 2'd3;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        MEMWB: begin
          reg_wr     = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          mem_wr     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        ALUWB: begin
          reg_wr     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'd1;
          pc_src     = 2'd1;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        ADDIWB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_en      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
        end
        default: err = 1'b1;
      endcase
    end
  end
endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, the maximum number of cycles spent waiting for mem_ready in a memory state before an error (range 1..255).
REQ-002 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register; funct  input  6  bits [5:0].
REQ-005 zero  input  1  ALU zero flag; mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-006 pc_en  output  1  PC load enable; pc_src  output  2  PC source (0 = ALU result, 1 = ALUOut register, 2 = jump target).
REQ-007 iord  output  1  memory address source (0 = PC, 1 = ALUOut); mem_rd, mem_wr  output  1 each  memory strobes; ir_wr  output  1  instruction register load.
REQ-008 reg_wr, reg_dst, mem_to_reg  output  1 each  register-file write enable, rd-vs-rt destination select, memory-vs-ALU writeback select.
REQ-009 alu_src_a  output  1  (0 = PC, 1 = rs); alu_src_b  output  2  (0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate); alu_op  output  2  (0 = add, 1 = subtract, 2 = decode by funct).
REQ-010 state  output  4  current state code; instr_done  output  1  one-cycle retire pulse; err  output  1  sticky fault flag.

Function
REQ-011 The block SHALL be a Moore-style FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERR=15; the outputs SHALL be decoded from state, mem_ready and zero only.
REQ-012 All outputs not listed for a state SHALL be 0 in that state.
REQ-013 FETCH SHALL drive mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1 and alu_op=0, and SHALL hold until mem_ready=1; in the ready cycle it SHALL drive ir_wr=1, pc_en=1 and pc_src=0, then go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=3 and alu_op=0 (branch-target precompute), then dispatch on opcode:
  - 000000 goes to EXEC.
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000100 (beq) goes to BRANCH.
  - 001000 (addi) goes to ADDIEX.
  - 000010 (j) goes to JUMP.
  - Any other opcode goes to ERR.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=0, then go to MEMRD for lw or to MEMWR for sw.
REQ-016 MEMRD SHALL drive mem_rd=1 and iord=1, waiting for mem_ready, then go to MEMWB.
REQ-017 MEMWB SHALL drive reg_wr=1, reg_dst=0 and mem_to_reg=1.
REQ-018 MEMWR SHALL drive mem_wr=1 and iord=1 and wait for mem_ready; it retires in the ready cycle.
REQ-019 EXEC SHALL drive alu_src_a=1, alu_src_b=0 and alu_op=2; ALUWB SHALL drive reg_wr=1, reg_dst=1 and mem_to_reg=0.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1 and pc_en=zero.
REQ-021 ADDIEX SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=0; ADDIWB SHALL drive reg_wr=1 and reg_dst=0.
REQ-022 JUMP SHALL drive pc_en=1 and pc_src=2.
REQ-023 instr_done SHALL pulse for exactly one cycle in the final cycle of each instruction:
  - MEMWB, ALUWB, BRANCH, ADDIWB, JUMP.
  - MEMWR in its ready cycle.
  - The final state SHALL then go to FETCH.
REQ-024 Instruction latencies with mem_ready tied high SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
REQ-025 An 8-bit wait counter SHALL reset to 0 on every state change and increment in each non-ready cycle of FETCH, MEMRD or MEMWR.
REQ-026 If the wait counter equals MEM_TIMEOUT while mem_ready=0, the FSM SHALL go to ERR on the next edge; mem_ready=1 on that same cycle SHALL win and the FSM SHALL proceed normally.
REQ-027 In ERR, err SHALL be 1 and all strobes 0; ERR SHALL be left only by reset.
REQ-028 funct SHALL NOT affect sequencing; it is consumed by the external ALU decoder only.

Reset
REQ-029 While rst=1, the block SHALL hold state=FETCH, wait counter=0 and err=0, with every registered output at 0, asynchronously and regardless of clk.
REQ-030 Assertion of rst mid-instruction, including during a memory wait, SHALL abort the instruction with no further pc_en, reg_wr or mem_wr pulse.
REQ-031 The first FETCH memory read SHALL be issued in the first cycle after rst deassertion.

Verification
REQ-032 The bench SHALL cover these directed scenarios with mem_ready=1:
  - R-type (opcode 0): state sequence 0,1,6,7,0; reg_wr=1 with reg_dst=1 only in state 7; instr_done high 1 cycle.
  - lw then sw: state sequences 0,1,2,3,4 and 0,1,2,5; mem_wr=1 for exactly 1 cycle with iord=1.
  - beq: zero=1 gives pc_en=1 with pc_src=1 in state 8; zero=0 gives pc_en=0; both return to FETCH after 3 cycles.
REQ-033 Wait-state scenario: lw with mem_ready low for 3 cycles in MEMRD SHALL stay in state 3 for 4 cycles, then go to MEMWB; err SHALL stay 0.
REQ-034 Timeout scenario: MEM_TIMEOUT=4 with mem_ready held 0 in FETCH SHALL reach state 15 and err=1 after 5 cycles; err SHALL stay set until rst.
REQ-035 Illegal-opcode and reset scenarios:
  - Opcode 111111 SHALL go DECODE to ERR.
  - rst pulsed while in MEMWR SHALL give state=0 immediately with mem_wr=0.
